// File: rtl/ysyx_22050612_muldiv_ctrl_if.sv
// Handshake and data bundle between EXU issue logic and the iterative mul/div sequencer.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface ysyx_22050612_muldiv_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22050612_muldiv_ctrl.sv
// Iterative RV64M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish one cycle after accept.
module ysyx_22050612_muldiv_ctrl (
    input  logic clk,
    input  logic rst,
    ysyx_22050612_muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_r;
    state_e      state_nx_s;
    logic [6:0]  cnt_r;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic [63:0] q_r;
    logic [63:0] result_r;
    logic        is_mul_r;
    logic        is_w_r;
    logic        is_rem_r;
    logic        neg_q_r;
    logic        neg_r_r;

    logic        in_ready_s;
    logic        out_valid_s;
    logic        busy_s;
    logic        accept_s;
    logic        op_is_mul_s;
    logic        op_is_w_s;
    logic        op_signed_s;
    logic        op_is_rem_s;
    logic [63:0] x_s;
    logic [63:0] y_s;
    logic        x_neg_s;
    logic        y_neg_s;
    logic [63:0] x_mag_s;
    logic [63:0] y_mag_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [63:0] special_res_s;

    logic [63:0] mul_acc_nx_s;
    logic [64:0] div_shift_s;
    logic        div_ge_s;
    logic [63:0] div_rem_nx_s;
    logic [63:0] div_quo_nx_s;
    logic [63:0] q_sgn_s;
    logic [63:0] r_sgn_s;
    logic [63:0] raw_s;
    logic [63:0] fin_s;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Operation decode, operand magnitudes and the special-case shortcut results.
    always_comb begin
        op_is_mul_s = (bus.op == 3'd0) || (bus.op == 3'd1);
        op_is_w_s   = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd7);
        op_signed_s = (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd5) || (bus.op == 3'd7);
        op_is_rem_s = (bus.op == 3'd5) || (bus.op == 3'd6) || (bus.op == 3'd7);
        x_s         = op_is_w_s ? sext32(bus.src1[31:0]) : bus.src1;
        y_s         = op_is_w_s ? sext32(bus.src2[31:0]) : bus.src2;
        x_neg_s     = op_signed_s && x_s[63];
        y_neg_s     = op_signed_s && y_s[63];
        x_mag_s     = x_neg_s ? (64'd0 - x_s) : x_s;
        y_mag_s     = y_neg_s ? (64'd0 - y_s) : y_s;
        div_zero_s  = !op_is_mul_s && (y_s == 64'd0);
        div_ovf_s   = op_signed_s && (y_s == {64{1'b1}}) &&
                      (x_s == (op_is_w_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special_s   = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_res_s = op_is_rem_s ? x_s : {64{1'b1}};
        end else if (div_ovf_s) begin
            special_res_s = op_is_rem_s ? 64'd0 : x_s;
        end else begin
            special_res_s = 64'd0;
        end
        accept_s = bus.in_valid && in_ready_s && !bus.flush;
    end

    // One iteration of either datapath plus the sign-fixed final result.
    always_comb begin
        mul_acc_nx_s = a_r + (q_r[0] ? b_r : 64'd0);
        div_shift_s  = {a_r, q_r[63]};
        div_ge_s     = (div_shift_s >= {1'b0, b_r});
        div_rem_nx_s = div_ge_s ? (div_shift_s[63:0] - b_r) : div_shift_s[63:0];
        div_quo_nx_s = {q_r[62:0], div_ge_s};
        q_sgn_s      = neg_q_r ? (64'd0 - div_quo_nx_s) : div_quo_nx_s;
        r_sgn_s      = neg_r_r ? (64'd0 - div_rem_nx_s) : div_rem_nx_s;
        if (is_mul_r) begin
            raw_s = mul_acc_nx_s;
        end else if (is_rem_r) begin
            raw_s = r_sgn_s;
        end else begin
            raw_s = q_sgn_s;
        end
        fin_s = is_w_r ? sext32(raw_s[31:0]) : raw_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == 7'd1) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = (state_r == ST_IDLE) && !rst;
        out_valid_s = (state_r == ST_DONE);
        busy_s      = (state_r != ST_IDLE);
    end

    // Operand load, per-cycle iteration and result capture on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 7'd0;
            a_r      <= 64'd0;
            b_r      <= 64'd0;
            q_r      <= 64'd0;
            result_r <= 64'd0;
            is_mul_r <= 1'b0;
            is_w_r   <= 1'b0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (bus.flush) begin
            cnt_r <= 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_mul_r <= op_is_mul_s;
                        is_w_r   <= op_is_w_s;
                        is_rem_r <= op_is_rem_s;
                        neg_q_r  <= x_neg_s ^ y_neg_s;
                        neg_r_r  <= x_neg_s;
                        a_r      <= 64'd0;
                        if (op_is_mul_s) begin
                            b_r <= op_is_w_s ? {32'd0, bus.src1[31:0]} : bus.src1;
                            q_r <= op_is_w_s ? {32'd0, bus.src2[31:0]} : bus.src2;
                        end else begin
                            b_r <= y_mag_s;
                            q_r <= op_is_w_s ? {x_mag_s[31:0], 32'd0} : x_mag_s;
                        end
                        if (special_s) begin
                            cnt_r    <= 7'd0;
                            result_r <= special_res_s;
                        end else begin
                            cnt_r <= op_is_w_s ? 7'd32 : 7'd64;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - 7'd1;
                    if (is_mul_r) begin
                        a_r <= mul_acc_nx_s;
                        b_r <= {b_r[62:0], 1'b0};
                        q_r <= {1'b0, q_r[63:1]};
                    end else begin
                        a_r <= div_rem_nx_s;
                        q_r <= div_quo_nx_s;
                    end
                    if (cnt_r == 7'd1) begin
                        result_r <= fin_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.busy      = busy_s;
    assign bus.result    = result_r;
endmodule

// File: doc/ysyx_22050612_muldiv_ctrl.md
# ysyx_22050612_muldiv_ctrl

Iterative multiply/divide sequencer for the RV64M ops recognised by the decoder (mul, mulw, div, divu, divw, rem, remu, remw). It sits beside the ALU in EXU.
- Accepts one operation at a time over a valid/ready handshake.
- Runs a radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Holds the result until the consumer takes it.
- Flush discards in-flight work on redirect.

## Interface
- XLEN, 64: operand/result width (fixed; W ops use low 32 bits)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE and rst low
- op  in  3  0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 DIVW, 5 REM, 6 REMU, 7 REMW
- src1  in  64  multiplicand / dividend
- src2  in  64  multiplier / divisor
- flush  in  1  abort current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  64  final result, stable while out_valid
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_valid & in_ready latches op/src1/src2.
  - Goes to CALC with cnt = 64 (MUL, DIV*, REM*) or 32 (W ops).
  - Special divides go directly to DONE.
- CALC: one iteration per cycle; cnt decrements; at cnt==1 the final iteration completes and the state goes to DONE.
- DONE: out_valid=1; on out_ready go to IDLE. in_ready=0 in DONE, so there is no same-cycle re-accept.
- flush=1 in any state: next state IDLE, out_valid 0, operands discarded. flush beats in_valid in the same cycle, so nothing is accepted.
- rst: state IDLE, cnt 0, result 0, out_valid 0, busy 0, in_ready 0 while rst high.
- Multiply: unsigned shift-add on the operands. Only the low 64 bits are kept; the sign is irrelevant to the low product.
  - MULW: low 32 bits of the 32x32 product, sign-extended to 64.
- Divide:
  - Signed ops (DIV, REM, DIVW, REMW) take magnitudes, run an unsigned restoring divide, then fix the sign at DONE entry.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - W ops take src[31:0] as signed 32-bit; the 32-bit result is sign-extended.
- Special cases, result in DONE 1 cycle after accept:
  - Divisor zero: quotient = all ones (W: 0xFFFFFFFF sign-extended = -1); remainder = dividend (W: sign-extended low 32).
  - Signed overflow (DIV: src1=0x8000000000000000, src2=-1; DIVW: 0x80000000, -1): quotient = dividend (sign-extended for W); remainder = 0.
  - Unsigned ops never overflow.
- result register updates only on DONE entry and holds its value afterwards (including after out_ready) until the next DONE entry or rst.

## Timing
- Accept at edge k (in_valid & in_ready sampled high).
- Normal op: out_valid high from cycle k+N+1, N=64 or 32.
  - MUL/DIV*/REM*: 65 cycles after accept.
  - W ops: 33 cycles after accept.
- Special divide: out_valid high in cycle k+1.
- out_valid/result hold indefinitely while out_ready=0.
- Handoff: out_valid & out_ready at edge m gives IDLE at m+1; in_ready=1 in cycle m+1.
- Minimum accept-to-accept spacing: N+2 cycles with out_ready tied high.
- Flush asserted in cycle j: busy=0, in_ready=1 in cycle j+1 (rst low). A flush in DONE drops the pending result even if out_ready=1 in the same cycle.
- rst mid-CALC: identical to flush, and result clears to 0.
- busy is registered state decode: high from k+1 through the handoff cycle.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1.
  - in_ready=0, out_valid=0, result=0 throughout.
  - in_ready=1 the cycle after rst falls.
- MUL 0xFFFFFFFFFFFFFFFF x 3:
  - result 0xFFFFFFFFFFFFFFFD, out_valid at accept+65.
  - MULW 0x7FFFFFFF x 2: result 0xFFFFFFFFFFFFFFFE at accept+33.
- Signed/unsigned divide:
  - DIV -7/2: result 0xFFFFFFFFFFFFFFFD (-3).
  - REM -7/2: result 0xFFFFFFFFFFFFFFFF (-1).
  - DIVU 100/7: result 14; REMU 100/7: result 2.
  - REMW 0x00000000FFFFFFF9/2: result -1.
- Specials:
  - DIVU x/0: result 0xFFFFFFFFFFFFFFFF.
  - REM 5/0: result 5.
  - DIV 0x8000000000000000/-1: result 0x8000000000000000.
  - DIVW 0x80000000/-1: result 0xFFFFFFFF80000000.
  - All four: out_valid at accept+1.
- Backpressure: out_ready low 10 cycles after DONE.
  - result stable, in_ready=0.
  - Raising out_ready gives in_ready=1 next cycle.
  - A new op is accepted and computed correctly.
- Flush:
  - Flush at accept+20 of a DIV: no out_valid, busy=0 next cycle.
  - Flush in the same cycle as in_valid: no accept.
  - Flush in DONE with out_ready=1: result dropped.
  - The following op completes normally.
